// File: rtl/boot_mem_mux.sv
// RAM port owner for the 6502 boot path: loader writes during boot, settle window
// with the CPU held in reset, then the CPU gets the port. Tracks checksum/count of the image.
module boot_mem_mux #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        ld_we,
    input  logic        ld_done,
    input  logic        reboot,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_reset,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_di,
    output logic        mem_we,
    input  logic [7:0]  mem_do,
    output logic        boot_done,
    output logic [7:0]  checksum,
    output logic [15:0] wr_count,
    output logic        late_wr
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] settle_cnt;
    logic [7:0] settle_cnt_nxt;
    logic       accept;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] wrap_add8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    // A write counts only while the loader owns the port and no reboot is pending.
    assign accept = ld_we && !reboot && (state == IDLE || state == LOAD);

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        case (state)
            IDLE: begin
                if (ld_we) begin
                    state_nxt = LOAD;
                end else if (ld_done) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = SETTLE_LOAD;
                end
            end
            LOAD: begin
                if (ld_done && !ld_we) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (settle_cnt == 8'd0) begin
                    state_nxt = RUN;
                end else begin
                    settle_cnt_nxt = settle_cnt - 8'd1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (reboot) begin
            state_nxt      = IDLE;
            settle_cnt_nxt = 8'd0;
        end
    end

    always_comb begin
        mem_addr = ld_addr;
        mem_di   = ld_data;
        mem_we   = ld_we;
        case (state)
            SETTLE: mem_we = 1'b0;
            RUN: begin
                mem_addr = cpu_addr;
                mem_di   = cpu_do;
                mem_we   = cpu_we;
            end
            default: ;
        endcase
    end

    assign cpu_di    = mem_do;
    assign cpu_reset = (state != RUN);
    assign boot_done = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            checksum   <= 8'd0;
            wr_count   <= 16'd0;
            late_wr    <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            if (reboot) begin
                checksum <= 8'd0;
                wr_count <= 16'd0;
                late_wr  <= 1'b0;
            end else begin
                if (accept) begin
                    checksum <= wrap_add8(checksum, ld_data);
                    wr_count <= sat_inc16(wr_count);
                end
                if (state == RUN && ld_we) begin
                    late_wr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_mem_mux.sv
// Directed and randomized bench for boot_mem_mux against a phase-level reference model.
module tb_boot_mem_mux;

    localparam int SC = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_we;
    logic        ld_done;
    logic        reboot;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_reset;
    logic [15:0] mem_addr;
    logic [7:0]  mem_di;
    logic        mem_we;
    logic [7:0]  mem_do;
    logic        boot_done;
    logic [7:0]  checksum;
    logic [15:0] wr_count;
    logic        late_wr;

    int total = 0;
    int bad   = 0;

    // Reference model: image bytes accepted so far, settle cycles remaining, running flag.
    byte unsigned img[$];
    int           m_settle;
    bit           m_run;
    bit           m_late;

    boot_mem_mux #(.SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_we(ld_we), .ld_done(ld_done),
        .reboot(reboot),
        .cpu_addr(cpu_addr), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di),
        .cpu_reset(cpu_reset),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_we(mem_we), .mem_do(mem_do),
        .boot_done(boot_done), .checksum(checksum), .wr_count(wr_count), .late_wr(late_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_sum();
        logic [7:0] s = 8'd0;
        foreach (img[i]) s = s + img[i];
        return s;
    endfunction

    function automatic logic [15:0] model_count();
        return (img.size() > 65535) ? 16'hFFFF : 16'(img.size());
    endfunction

    task automatic model_reset();
        img.delete();
        m_settle = 0;
        m_run    = 1'b0;
        m_late   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently held.
    task automatic model_edge();
        if (reboot) begin
            model_reset();
        end else if (m_run) begin
            if (ld_we) m_late = 1'b1;
        end else if (m_settle > 0) begin
            m_settle = m_settle - 1;
            if (m_settle == 0) m_run = 1'b1;
        end else if (ld_we) begin
            img.push_back(ld_data);
        end else if (ld_done) begin
            m_settle = SC;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        e_we;
        logic [15:0] e_addr;
        logic [7:0]  e_di;
        e_we   = m_run ? cpu_we : ((m_settle > 0) ? 1'b0 : ld_we);
        e_addr = m_run ? cpu_addr : ld_addr;
        e_di   = m_run ? cpu_do : ld_data;
        chk("cpu_reset", {15'd0, cpu_reset}, {15'd0, !m_run});
        chk("boot_done", {15'd0, boot_done}, {15'd0, m_run});
        chk("mem_we", {15'd0, mem_we}, {15'd0, e_we});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_di", {8'd0, mem_di}, {8'd0, e_di});
        chk("cpu_di", {8'd0, cpu_di}, {8'd0, mem_do});
        chk("checksum", {8'd0, checksum}, {8'd0, model_sum()});
        chk("wr_count", wr_count, model_count());
        chk("late_wr", {15'd0, late_wr}, {15'd0, m_late});
    endtask

    // Called at a falling edge: drive, check, take the rising edge, return at next falling edge.
    task automatic step(input logic we, input logic [15:0] a, input logic [7:0] d,
                        input logic done, input logic rb,
                        input logic cwe, input logic [15:0] ca, input logic [7:0] cd);
        ld_we    = we;
        ld_addr  = a;
        ld_data  = d;
        ld_done  = done;
        reboot   = rb;
        cpu_we   = cwe;
        cpu_addr = ca;
        cpu_do   = cd;
        mem_do   = 8'($urandom);
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(1'b1, a, d, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wait_step(input logic done);
        step(1'b0, 16'h0000, 8'h00, done, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic reboot_step();
        step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        ld_we = 1'b0; ld_done = 1'b1; reboot = 1'b0; ld_addr = 16'h0; ld_data = 8'h0;
        cpu_we = 1'b0; cpu_addr = 16'h0; cpu_do = 8'h0; mem_do = 8'h5A;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Empty load straight to SETTLE; CPU reset drops SC cycles after entry.
        wait_step(1'b1);
        for (int i = 0; i < SC - 1; i++) wait_step(1'b1);
        #1 chk("settle_still_reset", {15'd0, cpu_reset}, 16'd1);
        wait_step(1'b1);
        #1 chk("settle_release", {15'd0, boot_done}, 16'd1);
        chk("empty_checksum", {8'd0, checksum}, 16'h0000);

        // Three-byte image.
        reboot_step();
        wr(16'h8000, 8'hA9);
        wr(16'h8001, 8'h06);
        wr(16'h8002, 8'h69);
        wait_step(1'b1);
        chk("img3_checksum", {8'd0, checksum}, 16'h0018);
        chk("img3_count", wr_count, 16'd3);
        for (int i = 0; i < SC + 1; i++) wait_step(1'b1);

        // Write coinciding with done stays in LOAD.
        reboot_step();
        wr(16'h1000, 8'h10);
        step(1'b1, 16'h1001, 8'hFF, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        #1 chk("both_count", wr_count, 16'd2);
        chk("both_still_reset", {15'd0, cpu_reset}, 16'd1);
        for (int i = 0; i < SC + 1; i++) wait_step(1'b1);

        // CPU owns the port; late loader write flagged.
        step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b1, 16'h2410, 8'h42);
        step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0, 16'h2410, 8'h00);
        step(1'b1, 16'h0000, 8'h11, 1'b1, 1'b0, 1'b0, 16'h3000, 8'h00);
        #1 chk("late_set", {15'd0, late_wr}, 16'd1);

        // Reboot from RUN and reload.
        reboot_step();
        #1 chk("rb_reset", {15'd0, cpu_reset}, 16'd1);
        chk("rb_count", wr_count, 16'd0);
        chk("rb_late", {15'd0, late_wr}, 16'd0);
        wr(16'h0200, 8'h80);
        wr(16'h0201, 8'h80);
        wait_step(1'b0);
        chk("reload_checksum", {8'd0, checksum}, 16'h0000);
        chk("reload_count", wr_count, 16'd2);

        // Asynchronous reset in the middle of a load.
        for (int i = 0; i < 5; i++) wr(16'h4000 + 16'(i), 8'(i + 1));
        ld_we = 1'b1; ld_addr = 16'h4005; ld_data = 8'h77;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        chk("async_count", wr_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr(16'h5000, 8'h03);
        wr(16'h5001, 8'h04);
        wait_step(1'b0);
        chk("fresh_count", wr_count, 16'd2);
        chk("fresh_checksum", {8'd0, checksum}, 16'h0007);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 2) == 0, 16'($urandom), 8'($urandom),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
                 1'($urandom), 16'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_mem_mux.md
# boot_mem_mux

Sits directly downstream of the RAM loader. It owns the single RAM port of the 6502 system and gives it to the loader's write stream during boot. It then holds the CPU in reset for a settle window and hands the port to the CPU. While the image streams in, it accumulates a byte checksum and a write count so the load can be checked on the board.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: cycles between end of load and CPU reset release (legal range 1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ld_addr  in  16  loader write address
- ld_data  in  8  loader write data
- ld_we  in  1  loader write enable
- ld_done  in  1  loader finished / idle flag
- reboot  in  1  synchronous pulse: restart boot sequence
- cpu_addr  in  16  CPU address bus
- cpu_do  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_di  out  8  CPU read data (always equals mem_do)
- cpu_reset  out  1  active-high CPU reset
- mem_addr  out  16  RAM address
- mem_di  out  8  RAM write data
- mem_we  out  1  RAM write enable
- mem_do  in  8  RAM read data
- boot_done  out  1  high in RUN state only
- checksum  out  8  mod-256 sum of all loaded bytes
- wr_count  out  16  number of loader writes accepted, saturating at 16'hFFFF
- late_wr  out  1  sticky: loader wrote while in RUN

## Operation
- States:
  - IDLE (reset state)
  - LOAD
  - SETTLE
  - RUN
- The state is registered. The RAM port mux is combinational on the registered state.
- IDLE:
  - RAM port driven from the loader (mem_addr=ld_addr, mem_di=ld_data, mem_we=ld_we).
  - If ld_we=1: accept the write and go to LOAD.
  - Else if ld_done=1: go to SETTLE with nothing loaded.
  - ld_we has priority when both are high.
- LOAD:
  - RAM port driven from the loader.
  - Every cycle with ld_we=1: checksum += ld_data (mod 256), wr_count += 1 (saturating).
  - When ld_done=1 and ld_we=0: go to SETTLE.
  - If ld_done=1 and ld_we=1 in the same cycle: the write is accepted and the state stays LOAD.
- SETTLE:
  - mem_we=0, mem_addr=ld_addr, mem_di=ld_data.
  - A down-counter loads SETTLE_CYCLES-1 on entry and decrements each cycle.
  - When the counter reads 0: go to RUN.
- RUN:
  - RAM port driven from the CPU (mem_addr=cpu_addr, mem_di=cpu_do, mem_we=cpu_we).
  - Any ld_we=1 in RUN is not forwarded to RAM and sets late_wr.
- cpu_reset=1 in IDLE, LOAD and SETTLE; 0 in RUN.
- cpu_we is ignored outside RUN.
- reboot=1 in any state:
  - Next state is IDLE.
  - checksum, wr_count, late_wr and the settle counter clear to 0.
  - Any loader write in that same cycle is not counted, and is forwarded to RAM only if the current state is IDLE or LOAD.
- Checksum and count update only on accepted loader writes in IDLE or LOAD.

## Timing
- Reset values: state=IDLE, cpu_reset=1, boot_done=0, checksum=0, wr_count=0, late_wr=0, settle counter=0.
  - mem_we follows ld_we combinationally, because IDLE selects the loader.
- RAM write path has zero latency: loader or CPU signals appear on the mem_* pins in the same cycle.
- checksum and wr_count are registered: visible the cycle after the accepting edge.
- From the first SETTLE cycle, cpu_reset falls exactly SETTLE_CYCLES cycles later. boot_done rises on the same edge.
- late_wr sets on the edge after the offending ld_we cycle and clears only on rst_n or reboot.
- Reset mid-operation:
  - rst_n low at any time returns all state asynchronously to reset values, including cpu_reset=1.
  - Release is synchronized by the system-level reset synchronizer, not inside this block.

## Test plan
- Reset with ld_we=0, ld_done=1, SETTLE_CYCLES=4 -> IDLE→SETTLE; cpu_reset falls 4 cycles after SETTLE entry; checksum=00, wr_count=0.
- Writes A9@8000, 06@8001, 69@8002 on consecutive cycles, then ld_done=1 -> mem_we pulses on the same cycles with matching addresses; final checksum=0x18, wr_count=3; boot_done after SETTLE.
- Simultaneous ld_done=1 and ld_we=1 with data 0xFF -> write forwarded and counted; state stays LOAD; SETTLE entered the next cycle with ld_we=0.
- In RUN, CPU write 0x42 @2410 then read -> mem_we follows cpu_we, cpu_di=mem_do. A loader write 0x11 @0000 in RUN -> mem_we stays 0 for it; late_wr=1 the next cycle.
- reboot pulse in RUN -> next cycle IDLE, cpu_reset=1, checksum=0, wr_count=0, late_wr=0; re-load of 2 bytes 80,80 gives checksum=0x00, wr_count=2.
- rst_n asserted mid-LOAD after 5 writes -> outputs return to reset values immediately, without waiting for a clock edge; after release, a fresh load counts from 0.
